cpu7_csr_ctrl: RTL and testbench

CPU7_CSR_CTRL -- requirements
Module: cpu7_csr_ctrl

---
 rtl/cpu7_csr_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_cpu7_csr_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu7_csr_ctrl.sv
// CSR op / exception-entry / ERTN sequencer over a single-read, single-write CSR file.
// Ops respond 2 cycles after accept; entry takes 3 write cycles, return 2; new requests wait until IDLE.
module cpu7_csr_ctrl #(
  parameter int GRLEN   = 32,
  parameter int CSR_BIT = 14
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [1:0]         op_type,
  input  logic [CSR_BIT-1:0] op_addr,
  input  logic [GRLEN-1:0]   op_wdata,
  input  logic [GRLEN-1:0]   op_mask,
  output logic               op_done,
  output logic [GRLEN-1:0]   op_rdata,
  input  logic               excp_valid,
  input  logic [GRLEN-1:0]   excp_pc,
  output logic               excp_done,
  input  logic               ertn_valid,
  output logic               ertn_done,
  output logic [GRLEN-1:0]   ertn_era,
  output logic [CSR_BIT-1:0] csr_raddr,
  input  logic [GRLEN-1:0]   csr_rdata,
  output logic [CSR_BIT-1:0] csr_waddr,
  output logic [GRLEN-1:0]   csr_wdata,
  output logic               csr_wen,
  output logic               busy
);

  localparam logic [CSR_BIT-1:0] CRMD_A = CSR_BIT'(0);
  localparam logic [CSR_BIT-1:0] PRMD_A = CSR_BIT'(1);
  localparam logic [CSR_BIT-1:0] ERA_A  = CSR_BIT'(6);

  typedef enum logic [2:0] {
    IDLE, OP_EXEC, OP_RESP, EX_PRMD, EX_ERA, EX_CRMD, RT_CRMD, RT_ERA
  } state_t;

  state_t state_q, state_d;

  logic [1:0]         type_q,  type_d;
  logic [CSR_BIT-1:0] addr_q,  addr_d;
  logic [GRLEN-1:0]   wdata_q, wdata_d;
  logic [GRLEN-1:0]   mask_q,  mask_d;
  logic [GRLEN-1:0]   old_q,   old_d;
  logic [GRLEN-1:0]   pc_q,    pc_d;
  logic [GRLEN-1:0]   crmd_q,  crmd_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (excp_valid)      state_d = EX_PRMD;
        else if (ertn_valid) state_d = RT_CRMD;
        else if (op_valid)   state_d = OP_EXEC;
      end
      OP_EXEC: state_d = OP_RESP;
      OP_RESP: state_d = IDLE;
      EX_PRMD: state_d = EX_ERA;
      EX_ERA:  state_d = EX_CRMD;
      EX_CRMD: state_d = IDLE;
      RT_CRMD: state_d = RT_ERA;
      RT_ERA:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // csr_raddr is 0 in IDLE, so an ERTN accept latches the live CRMD for RT_CRMD.
  always_comb begin
    type_d  = type_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    old_d   = old_q;
    pc_d    = pc_q;
    crmd_d  = crmd_q;
    unique case (state_q)
      IDLE: begin
        if (excp_valid) begin
          pc_d = excp_pc;
        end else if (ertn_valid) begin
          crmd_d = csr_rdata;
        end else if (op_valid) begin
          type_d  = op_type;
          addr_d  = op_addr;
          wdata_d = op_wdata;
          mask_d  = op_mask;
        end
      end
      OP_EXEC: old_d  = csr_rdata;
      EX_PRMD: crmd_d = csr_rdata;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      type_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      old_q   <= '0;
      pc_q    <= '0;
      crmd_q  <= '0;
    end else begin
      type_q  <= type_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      old_q   <= old_d;
      pc_q    <= pc_d;
      crmd_q  <= crmd_d;
    end
  end

  always_comb begin
    op_ready  = 1'b0;
    op_done   = 1'b0;
    excp_done = 1'b0;
    ertn_done = 1'b0;
    ertn_era  = '0;
    csr_raddr = '0;
    csr_waddr = '0;
    csr_wdata = '0;
    csr_wen   = 1'b0;
    busy      = (state_q != IDLE);
    op_rdata  = old_q;
    unique case (state_q)
      IDLE: op_ready = !excp_valid && !ertn_valid;
      OP_EXEC: begin
        csr_raddr = addr_q;
        csr_waddr = addr_q;
        // op_type 2'b11 falls through as a plain read
        if (type_q == 2'b01) begin
          csr_wen   = 1'b1;
          csr_wdata = wdata_q;
        end else if (type_q == 2'b10) begin
          csr_wen   = 1'b1;
          csr_wdata = (wdata_q & mask_q) | (csr_rdata & ~mask_q);
        end
      end
      OP_RESP: op_done = 1'b1;
      EX_PRMD: begin
        csr_raddr = CRMD_A;
        csr_wen   = 1'b1;
        csr_waddr = PRMD_A;
        csr_wdata = {{(GRLEN-3){1'b0}}, csr_rdata[2:0]};
      end
      EX_ERA: begin
        csr_wen   = 1'b1;
        csr_waddr = ERA_A;
        csr_wdata = pc_q;
      end
      EX_CRMD: begin
        csr_wen   = 1'b1;
        csr_waddr = CRMD_A;
        csr_wdata = {crmd_q[GRLEN-1:3], 3'b000};
        excp_done = 1'b1;
      end
      RT_CRMD: begin
        csr_raddr = PRMD_A;
        csr_wen   = 1'b1;
        csr_waddr = CRMD_A;
        csr_wdata = {crmd_q[GRLEN-1:3], csr_rdata[2:0]};
      end
      RT_ERA: begin
        csr_raddr = ERA_A;
        ertn_done = 1'b1;
        ertn_era  = csr_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu7_csr_ctrl.sv
// Directed bench for cpu7_csr_ctrl with a small 8-entry CSR file model.
module tb_cpu7_csr_ctrl;

  logic        clk;
  logic        resetn;
  logic        op_valid, op_ready, op_done;
  logic [1:0]  op_type;
  logic [13:0] op_addr;
  logic [31:0] op_wdata, op_mask, op_rdata;
  logic        excp_valid, excp_done;
  logic [31:0] excp_pc;
  logic        ertn_valid, ertn_done;
  logic [31:0] ertn_era;
  logic [13:0] csr_raddr, csr_waddr;
  logic [31:0] csr_rdata, csr_wdata;
  logic        csr_wen, busy;

  logic [31:0] mem [0:7];
  logic        pre_en;
  logic [2:0]  pre_addr;
  logic [31:0] pre_val;
  int          wr_cnt;

  int n_chk;
  int n_fail;

  cpu7_csr_ctrl #(.GRLEN(32), .CSR_BIT(14)) dut (
    .clk(clk), .resetn(resetn),
    .op_valid(op_valid), .op_ready(op_ready), .op_type(op_type),
    .op_addr(op_addr), .op_wdata(op_wdata), .op_mask(op_mask),
    .op_done(op_done), .op_rdata(op_rdata),
    .excp_valid(excp_valid), .excp_pc(excp_pc), .excp_done(excp_done),
    .ertn_valid(ertn_valid), .ertn_done(ertn_done), .ertn_era(ertn_era),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .csr_wen(csr_wen),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign csr_rdata = mem[csr_raddr[2:0]];

  always @(posedge clk) begin
    if (csr_wen) begin
      mem[csr_waddr[2:0]] <= csr_wdata;
      wr_cnt <= wr_cnt + 1;
    end else if (pre_en) begin
      mem[pre_addr] <= pre_val;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [2:0] a, input logic [31:0] v);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_val = v;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  typ;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [31:0] mask;
    logic [31:0] pre;
    logic        exp_wen;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [6];
  int   saved_wr;

  initial begin
    vecs[0] = '{2'b10, 14'h0, 32'h4,          32'h4,          32'h3,          1'b1, 32'h7};
    vecs[1] = '{2'b01, 14'h6, 32'h1c000000,   32'h0,          32'h12345678,   1'b1, 32'h1c000000};
    vecs[2] = '{2'b00, 14'h1, 32'hffffffff,   32'hffffffff,   32'hA5,         1'b0, 32'h0};
    vecs[3] = '{2'b11, 14'h2, 32'hffffffff,   32'hffffffff,   32'h55,         1'b0, 32'h0};
    vecs[4] = '{2'b10, 14'h2, 32'hFFFF0000,   32'h0F0F0F0F,   32'h12345678,   1'b1, 32'h1F3F5070};
    vecs[5] = '{2'b10, 14'h1, 32'hffffffff,   32'h0,          32'hDEAD0001,   1'b1, 32'hDEAD0001};

    n_chk = 0; n_fail = 0; wr_cnt = 0;
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    pre_en = 0; pre_addr = 0; pre_val = 0;
    op_valid = 0; op_type = 0; op_addr = 0; op_wdata = 0; op_mask = 0;
    excp_valid = 0; excp_pc = 0; ertn_valid = 0;
    resetn = 1'b1;
    #2 resetn = 1'b0;
    #5;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wen", 32'(csr_wen), 0);
    chk("rst_op_done", 32'(op_done), 0);
    chk("rst_excp_done", 32'(excp_done), 0);
    chk("rst_ertn_done", 32'(ertn_done), 0);
    chk("rst_op_rdata", op_rdata, 0);
    chk("rst_ertn_era", ertn_era, 0);
    chk("rst_raddr", 32'(csr_raddr), 0);
    chk("rst_op_ready", 32'(op_ready), 1);
    @(negedge clk);
    resetn = 1'b1;

    // Table of single ops
    foreach (vecs[i]) begin
      preload(vecs[i].addr[2:0], vecs[i].pre);
      @(negedge clk);
      op_valid = 1; op_type = vecs[i].typ; op_addr = vecs[i].addr;
      op_wdata = vecs[i].wdata; op_mask = vecs[i].mask;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(op_ready), 1);
      @(negedge clk);
      op_valid = 0;
      #1;
      chk($sformatf("v%0d_exec_busy", i), 32'(busy), 1);
      chk($sformatf("v%0d_exec_raddr", i), 32'(csr_raddr), 32'(vecs[i].addr));
      chk($sformatf("v%0d_exec_wen", i), 32'(csr_wen), 32'(vecs[i].exp_wen));
      if (vecs[i].exp_wen) begin
        chk($sformatf("v%0d_waddr", i), 32'(csr_waddr), 32'(vecs[i].addr));
        chk($sformatf("v%0d_wdata", i), csr_wdata, vecs[i].exp_wdata);
      end
      @(negedge clk); #1;
      chk($sformatf("v%0d_done", i), 32'(op_done), 1);
      chk($sformatf("v%0d_rdata", i), op_rdata, vecs[i].pre);
      chk($sformatf("v%0d_resp_wen", i), 32'(csr_wen), 0);
      chk($sformatf("v%0d_resp_raddr", i), 32'(csr_raddr), 0);
      @(negedge clk); #1;
      chk($sformatf("v%0d_done_drop", i), 32'(op_done), 0);
      chk($sformatf("v%0d_idle", i), 32'(busy), 0);
      chk($sformatf("v%0d_mem", i), mem[vecs[i].addr[2:0]],
          vecs[i].exp_wen ? vecs[i].exp_wdata : vecs[i].pre);
    end

    // Exception entry with CRMD=7
    preload(3'd0, 32'h7);
    @(negedge clk);
    excp_valid = 1; excp_pc = 32'h1c000100;
    #1 chk("ex_op_ready", 32'(op_ready), 0);
    @(negedge clk);
    excp_valid = 0;
    #1;
    chk("ex1_wen", 32'(csr_wen), 1);
    chk("ex1_waddr", 32'(csr_waddr), 1);
    chk("ex1_wdata", csr_wdata, 32'h7);
    chk("ex1_done", 32'(excp_done), 0);
    @(negedge clk); #1;
    chk("ex2_wen", 32'(csr_wen), 1);
    chk("ex2_waddr", 32'(csr_waddr), 6);
    chk("ex2_wdata", csr_wdata, 32'h1c000100);
    @(negedge clk); #1;
    chk("ex3_wen", 32'(csr_wen), 1);
    chk("ex3_waddr", 32'(csr_waddr), 0);
    chk("ex3_wdata", csr_wdata, 32'h0);
    chk("ex3_done", 32'(excp_done), 1);
    @(negedge clk); #1;
    chk("ex4_idle", 32'(busy), 0);
    chk("ex4_wen", 32'(csr_wen), 0);
    chk("ex4_done", 32'(excp_done), 0);

    // ERTN with PRMD=7, ERA=0x1c000100, CRMD=0
    @(negedge clk);
    ertn_valid = 1;
    #1 chk("rt_op_ready", 32'(op_ready), 0);
    @(negedge clk);
    ertn_valid = 0;
    #1;
    chk("rt1_wen", 32'(csr_wen), 1);
    chk("rt1_waddr", 32'(csr_waddr), 0);
    chk("rt1_wdata", csr_wdata, 32'h7);
    chk("rt1_done", 32'(ertn_done), 0);
    @(negedge clk); #1;
    chk("rt2_done", 32'(ertn_done), 1);
    chk("rt2_era", ertn_era, 32'h1c000100);
    chk("rt2_wen", 32'(csr_wen), 0);
    @(negedge clk); #1;
    chk("rt3_idle", 32'(busy), 0);
    chk("rt3_done", 32'(ertn_done), 0);

    // All three requests at once: exception, then ertn, then op
    @(negedge clk);
    op_valid = 1; op_type = 2'b00; op_addr = 14'h6;
    excp_valid = 1; excp_pc = 32'h1c000200; ertn_valid = 1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) excp_valid = 0;
      if (c == 5) ertn_valid = 0;
      if (c == 8) op_valid = 0;
      #1;
      chk($sformatf("pri%0d_ready", c), 32'(op_ready), 32'(c == 7));
      chk($sformatf("pri%0d_excp_done", c), 32'(excp_done), 32'(c == 3));
      chk($sformatf("pri%0d_ertn_done", c), 32'(ertn_done), 32'(c == 6));
      chk($sformatf("pri%0d_op_done", c), 32'(op_done), 32'(c == 9));
      if (c == 5) chk("pri5_crmd_wdata", csr_wdata, 32'h7);
      if (c == 6) chk("pri6_era", ertn_era, 32'h1c000200);
      if (c == 9) chk("pri9_rdata", op_rdata, 32'h1c000200);
    end

    // Exception arriving during OP_EXEC waits for the op to finish
    @(negedge clk);
    op_valid = 1; op_type = 2'b01; op_addr = 14'h2; op_wdata = 32'h99;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) begin op_valid = 0; excp_valid = 1; excp_pc = 32'h1c000300; end
      if (c == 4) excp_valid = 0;
      #1;
      chk($sformatf("late%0d_op_done", c), 32'(op_done), 32'(c == 2));
      chk($sformatf("late%0d_excp_done", c), 32'(excp_done), 32'(c == 6));
      chk($sformatf("late%0d_busy", c), 32'(busy), 32'(c != 0 && c != 3));
      if (c == 2) chk("late2_rdata", op_rdata, 32'h1F3F5070);
      if (c == 3) chk("late3_ready", 32'(op_ready), 0);
      if (c == 4) chk("late4_waddr", 32'(csr_waddr), 1);
    end
    @(negedge clk); #1;
    chk("late_mem2", mem[2], 32'h99);
    chk("late_mem6", mem[6], 32'h1c000300);

    // Reset in the middle of entry, during EX_ERA
    preload(3'd0, 32'h5);
    @(negedge clk);
    excp_valid = 1; excp_pc = 32'h1c000400;
    @(negedge clk);
    excp_valid = 0;
    #1 chk("mr_prmd_wdata", csr_wdata, 32'h5);
    @(negedge clk); #1;
    chk("mr_era_waddr", 32'(csr_waddr), 6);
    resetn = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 0);
    chk("mr_wen", 32'(csr_wen), 0);
    chk("mr_op_rdata", op_rdata, 0);
    saved_wr = wr_cnt;
    @(negedge clk); #1;
    chk("mr_no_writes", 32'(wr_cnt), 32'(saved_wr));
    chk("mr_excp_done", 32'(excp_done), 0);
    chk("mr_crmd", mem[0], 32'h5);
    chk("mr_era", mem[6], 32'h1c000300);
    resetn = 1'b1;
    @(negedge clk); #1;
    chk("mr_after_busy", 32'(busy), 0);
    chk("mr_after_ready", 32'(op_ready), 1);
    chk("mr_after_done", 32'(excp_done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
